// File: rtl/ball_speed_ctrl_pkg.sv
// Shared definitions for the table-tennis ball speed controller.
package ball_speed_ctrl_pkg;

  localparam int PERIOD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RUN   = 2'd2,
    ST_ENDED = 2'd3
  } state_e;

endpackage

// File: rtl/ball_speed_ctrl_period_counter.sv
// Programmable terminal-count counter: runs 0..tc, raises wrap on the terminal count.
module period_counter
  import ball_speed_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] tc,
  output logic                wrap
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == tc);

  // clr has priority so a hit/miss restarts the period even on a wrap cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == tc) cnt_d = '0;
      else             cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_speed_ctrl.sv
// Ball step scheduler: serve delay, accelerating rally ticks and point-end hold.
module ball_speed_ctrl
  import ball_speed_ctrl_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] BASE_PERIOD = 32'd999_999,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 32'd249_999,
  parameter logic [PERIOD_W-1:0] STEP        = 32'd50_000,
  parameter logic [PERIOD_W-1:0] SERVE_WAIT  = 32'd50,
  parameter logic [PERIOD_W-1:0] END_WAIT    = 32'd100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hit,
  input  logic                miss,
  input  logic                pause,
  output logic                step_tick,
  output logic                busy,
  output logic [PERIOD_W-1:0] period,
  output logic [1:0]          state
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] wait_q, wait_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;
  logic                cnt_en, cnt_clr, wrap;

  // One extra bit keeps period-STEP from wrapping around when STEP > period
  function automatic logic [PERIOD_W-1:0] dec_period(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W:0] diff;
    diff = {1'b0, p} - {1'b0, STEP};
    if (diff[PERIOD_W] || (diff[PERIOD_W-1:0] < MIN_PERIOD)) return MIN_PERIOD;
    return diff[PERIOD_W-1:0];
  endfunction

  period_counter u_period_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .tc   (period_q),
    .wrap (wrap)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    period_d = period_q;
    tick_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = !pause && (state_q != ST_IDLE);
    if (!pause) begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          if (start) begin
            state_d  = ST_SERVE;
            wait_d   = '0;
            period_d = BASE_PERIOD;
          end
        end
        ST_SERVE: begin
          if (wrap) begin
            if (wait_q + 32'd1 >= SERVE_WAIT) begin
              state_d = ST_RUN;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + 32'd1;
            end
          end
        end
        ST_RUN: begin
          if (miss) begin
            state_d  = ST_ENDED;
            wait_d   = '0;
            period_d = BASE_PERIOD;
            cnt_clr  = 1'b1;
          end else if (hit) begin
            period_d = dec_period(period_q);
            cnt_clr  = 1'b1;
          end else if (wrap) begin
            tick_d = 1'b1;
          end
        end
        ST_ENDED: begin
          if (wrap) begin
            if (wait_q + 32'd1 >= END_WAIT) begin
              state_d = ST_IDLE;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + 32'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      period_q <= BASE_PERIOD;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign step_tick = tick_q;
  assign busy      = busy_q;
  assign period    = period_q;
  assign state     = state_q;

endmodule
